// File: rtl/ppu_bg_fetcher.sv
// ppu_bg_fetcher
// Fetches one scanline's worth of background tiles from PPU memory.
// Each tile takes four reads: nametable, attribute, pattern low and pattern
// high. Every read takes two cycles: the address is presented, and the data
// comes back one cycle later. Finished tiles are handed to the consumer
// through a valid/ready holding register.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start_line        one-cycle request to fetch NUM_TILES tiles
//   tile_x0, tile_y   starting coarse X and coarse Y, latched with start_line
//   fine_y            pixel row within the tile, latched with start_line
//   nt_sel, pt_base   nametable and pattern table select, latched with start_line
//   mem_addr/rw/data  request side of the PPU memory wrapper (read-only use)
//   mem_q             read data, valid the cycle after mem_addr
//   tile_valid/ready  output handshake
//   tile_lo/hi/idx    pattern bitplanes and nametable byte of the held tile
//   tile_pal          palette select of the held tile
//   busy, done        high outside IDLE; one-cycle pulse on the last tile load
module ppu_bg_fetcher #(
  parameter int NUM_TILES = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_line,
  input  logic [4:0]  tile_x0,
  input  logic [4:0]  tile_y,
  input  logic [2:0]  fine_y,
  input  logic [1:0]  nt_sel,
  input  logic        pt_base,
  output logic [13:0] mem_addr,
  output logic        mem_rw,
  output logic [7:0]  mem_data,
  input  logic [7:0]  mem_q,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [7:0]  tile_lo,
  output logic [7:0]  tile_hi,
  output logic [7:0]  tile_idx,
  output logic [1:0]  tile_pal,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, NT_A, NT_D, AT_A, AT_D, LO_A, LO_D, HI_A, HI_D, WAIT
  } state_t;

  localparam logic [6:0] LAST_CNT = 7'(NUM_TILES - 1);

  state_t     state;
  logic [4:0] cur_x;
  logic [4:0] cur_y;
  logic [2:0] cur_fine_y;
  logic [1:0] cur_nt;
  logic       cur_pt;
  logic [6:0] tile_cnt;
  logic [7:0] nt_byte;
  logic [7:0] at_byte;
  logic [7:0] lo_byte;
  logic [7:0] hi_byte;

  logic [4:0] next_x;
  logic [1:0] next_nt;
  logic       slot_free;
  logic       load_now;
  logic [7:0] load_hi;
  logic [1:0] pal_sel;

  // Nametable address: 0x2000 | nt<<10 | y<<5 | x.
  function automatic logic [13:0] nt_addr(input logic [1:0] nt,
                                          input logic [4:0] y,
                                          input logic [4:0] x);
    return {2'b10, nt, y, x};
  endfunction

  // Attribute address: 0x23C0 | nt<<10 | (y>>2)<<3 | (x>>2).
  function automatic logic [13:0] at_addr(input logic [1:0] nt,
                                          input logic [2:0] y_hi,
                                          input logic [2:0] x_hi);
    return {2'b10, nt, 4'b1111, y_hi, x_hi};
  endfunction

  // Pattern address: pt<<12 | idx<<4 | plane<<3 | fine_y.
  function automatic logic [13:0] pat_addr(input logic       pt,
                                           input logic [7:0] idx,
                                           input logic       plane,
                                           input logic [2:0] row);
    return {1'b0, pt, idx, plane, row};
  endfunction

  assign mem_rw   = 1'b0;
  assign mem_data = 8'h00;

  // Next tile position: x wraps 31->0 and the horizontal nametable bit flips
  // on that wrap, so a line can straddle two nametables.
  assign next_x  = cur_x + 5'd1;
  assign next_nt = {cur_nt[1], cur_nt[0] ^ (cur_x == 5'd31)};

  // A tile can be loaded when the holding register is empty, or when it is
  // being emptied in this same cycle. From HI_D the high byte is still on
  // mem_q. From WAIT it was parked in hi_byte.
  assign slot_free = !tile_valid || tile_ready;
  assign load_now  = ((state == HI_D) || (state == WAIT)) && slot_free;
  assign load_hi   = (state == HI_D) ? mem_q : hi_byte;

  // Each attribute byte covers a 4x4 tile area in 2x2 quadrants. Bit 1 of y
  // and bit 1 of x together pick which 2-bit field applies to this tile.
  always_comb begin
    pal_sel = at_byte[1:0];
    case ({cur_y[1], cur_x[1]})
      2'b00: pal_sel = at_byte[1:0];
      2'b01: pal_sel = at_byte[3:2];
      2'b10: pal_sel = at_byte[5:4];
      2'b11: pal_sel = at_byte[7:6];
      default: pal_sel = at_byte[1:0];
    endcase
  end

  // The fetch sequencer. Every *_A state is entered with mem_addr already set
  // up on the transition edge. This lets the address appear in the *_A cycle
  // and stay put through *_D, where mem_q is captured. The output register
  // handshake lives here as well, so load and transfer share one update
  // point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_fine_y <= '0;
      cur_nt     <= '0;
      cur_pt     <= 1'b0;
      tile_cnt   <= '0;
      nt_byte    <= '0;
      at_byte    <= '0;
      lo_byte    <= '0;
      hi_byte    <= '0;
      mem_addr   <= '0;
      tile_valid <= 1'b0;
      tile_lo    <= '0;
      tile_hi    <= '0;
      tile_idx   <= '0;
      tile_pal   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tile_valid && tile_ready) begin
        tile_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_line) begin
            cur_x      <= tile_x0;
            cur_y      <= tile_y;
            cur_fine_y <= fine_y;
            cur_nt     <= nt_sel;
            cur_pt     <= pt_base;
            tile_cnt   <= '0;
            mem_addr   <= nt_addr(nt_sel, tile_y, tile_x0);
            busy       <= 1'b1;
            state      <= NT_A;
          end
        end
        NT_A: state <= NT_D;
        NT_D: begin
          nt_byte  <= mem_q;
          mem_addr <= at_addr(cur_nt, cur_y[4:2], cur_x[4:2]);
          state    <= AT_A;
        end
        AT_A: state <= AT_D;
        AT_D: begin
          at_byte  <= mem_q;
          mem_addr <= pat_addr(cur_pt, nt_byte, 1'b0, cur_fine_y);
          state    <= LO_A;
        end
        LO_A: state <= LO_D;
        LO_D: begin
          lo_byte  <= mem_q;
          mem_addr <= pat_addr(cur_pt, nt_byte, 1'b1, cur_fine_y);
          state    <= HI_A;
        end
        HI_A: state <= HI_D;
        HI_D: begin
          hi_byte <= mem_q;
          if (!slot_free) begin
            state <= WAIT;
          end
        end
        WAIT: state <= WAIT;
        default: state <= IDLE;
      endcase

      // Completing a tile: load the holding register, advance to the next
      // tile position, then either start its nametable fetch or finish the
      // line.
      if (load_now) begin
        tile_valid <= 1'b1;
        tile_idx   <= nt_byte;
        tile_lo    <= lo_byte;
        tile_hi    <= load_hi;
        tile_pal   <= pal_sel;
        cur_x      <= next_x;
        cur_nt     <= next_nt;
        tile_cnt   <= tile_cnt + 7'd1;
        if (tile_cnt == LAST_CNT) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          mem_addr <= nt_addr(next_nt, cur_y, next_x);
          state    <= NT_A;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// tb_ppu_bg_fetcher
// Directed bench for ppu_bg_fetcher. Three instances with NUM_TILES of 1, 2
// and 3 share a behavioural PPU memory. The memory has a registered read
// port, so data arrives the cycle after the address. Cycle numbers in the
// tests count from the start_line cycle (cycle 0). Outputs are sampled on
// the falling edge.
module tb_ppu_bg_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_line [3];
  logic [4:0]  tile_x0;
  logic [4:0]  tile_y;
  logic [2:0]  fine_y;
  logic [1:0]  nt_sel;
  logic        pt_base;
  logic        tile_ready [3];
  logic [13:0] mem_addr [3];
  logic        mem_rw [3];
  logic [7:0]  mem_data [3];
  logic [7:0]  mem_q [3];
  logic        tile_valid [3];
  logic [7:0]  tile_lo [3];
  logic [7:0]  tile_hi [3];
  logic [7:0]  tile_idx [3];
  logic [1:0]  tile_pal [3];
  logic        busy [3];
  logic        done [3];

  logic [7:0]  mem [0:16383];
  logic [13:0] addr_tr [0:63];
  logic        valid_tr [0:63];
  logic        done_tr [0:63];
  logic        busy_tr [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    ppu_bg_fetcher #(.NUM_TILES(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start_line (start_line[g]),
      .tile_x0    (tile_x0),
      .tile_y     (tile_y),
      .fine_y     (fine_y),
      .nt_sel     (nt_sel),
      .pt_base    (pt_base),
      .mem_addr   (mem_addr[g]),
      .mem_rw     (mem_rw[g]),
      .mem_data   (mem_data[g]),
      .mem_q      (mem_q[g]),
      .tile_valid (tile_valid[g]),
      .tile_ready (tile_ready[g]),
      .tile_lo    (tile_lo[g]),
      .tile_hi    (tile_hi[g]),
      .tile_idx   (tile_idx[g]),
      .tile_pal   (tile_pal[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) mem_q[i] <= mem[mem_addr[i]];
  end

  task automatic setup_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2000] = 8'h24; mem[14'h23C0] = 8'hE4;
    mem[14'h0243] = 8'h11; mem[14'h024B] = 8'h22;
    mem[14'h20A6] = 8'h30; mem[14'h23C9] = 8'hE4;
    mem[14'h1300] = 8'h5A; mem[14'h1308] = 8'hA5;
    mem[14'h201F] = 8'h01; mem[14'h2400] = 8'h07;
    mem[14'h2822] = 8'h41; mem[14'h2823] = 8'h42; mem[14'h2824] = 8'h43;
    mem[14'h2BC0] = 8'h1B; mem[14'h2BC1] = 8'h03;
    mem[14'h0411] = 8'hA1; mem[14'h0419] = 8'hB1;
    mem[14'h0421] = 8'hA2; mem[14'h0429] = 8'hB2;
    mem[14'h0431] = 8'hA3; mem[14'h0439] = 8'hB3;
  endtask

  task automatic set_inputs(input logic [4:0] x, input logic [4:0] y,
                            input logic [2:0] fy, input logic [1:0] nt,
                            input logic pt);
    tile_x0 = x; tile_y = y; fine_y = fy; nt_sel = nt; pt_base = pt;
  endtask

  // Pulses start_line for one cycle (cycle 0) and returns at the falling
  // edge of cycle 1.
  task automatic pulse_start(input int d);
    @(negedge clk);
    start_line[d] = 1'b1;
    @(negedge clk);
    start_line[d] = 1'b0;
  endtask

  // Records instance d from cycle 1 through cycle n.
  task automatic capture(input int d, input int n);
    for (int c = 1; c <= n; c++) begin
      addr_tr[c]  = mem_addr[d];
      valid_tr[c] = tile_valid[d];
      done_tr[c]  = done[d];
      busy_tr[c]  = busy[d];
      if (c < n) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (mem_addr[d] !== 14'h0) begin errors++; $display("[TB] FAIL reset_addr[%0d] got=%h exp=0000", d, mem_addr[d]); end
      checks++; if ({tile_valid[d], busy[d], done[d]} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags[%0d] got=%b exp=000", d, {tile_valid[d], busy[d], done[d]}); end
      checks++; if ({tile_lo[d], tile_hi[d], tile_idx[d], tile_pal[d]} !== 26'h0) begin errors++; $display("[TB] FAIL reset_tile[%0d] got=%h exp=0", d, {tile_lo[d], tile_hi[d], tile_idx[d], tile_pal[d]}); end
      checks++; if ({mem_rw[d], mem_data[d]} !== 9'h0) begin errors++; $display("[TB] FAIL reset_wr[%0d] got=%h exp=0", d, {mem_rw[d], mem_data[d]}); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    set_inputs(5'd0, 5'd0, 3'd3, 2'd0, 1'b0);
    pulse_start(0);
    capture(0, 12);
    checks++; if (addr_tr[1] !== 14'h2000) begin errors++; $display("[TB] FAIL basic_nt_addr got=%h exp=2000", addr_tr[1]); end
    checks++; if (addr_tr[2] !== 14'h2000) begin errors++; $display("[TB] FAIL basic_nt_hold got=%h exp=2000", addr_tr[2]); end
    checks++; if (addr_tr[3] !== 14'h23C0) begin errors++; $display("[TB] FAIL basic_at_addr got=%h exp=23c0", addr_tr[3]); end
    checks++; if (addr_tr[5] !== 14'h0243) begin errors++; $display("[TB] FAIL basic_lo_addr got=%h exp=0243", addr_tr[5]); end
    checks++; if (addr_tr[7] !== 14'h024B) begin errors++; $display("[TB] FAIL basic_hi_addr got=%h exp=024b", addr_tr[7]); end
    checks++; if (addr_tr[10] !== 14'h024B) begin errors++; $display("[TB] FAIL basic_idle_hold got=%h exp=024b", addr_tr[10]); end
    checks++; if ({valid_tr[8], valid_tr[9], valid_tr[10]} !== 3'b010) begin errors++; $display("[TB] FAIL basic_valid_8_9_10 got=%b exp=010", {valid_tr[8], valid_tr[9], valid_tr[10]}); end
    checks++; if ({done_tr[8], done_tr[9], done_tr[10]} !== 3'b010) begin errors++; $display("[TB] FAIL basic_done_8_9_10 got=%b exp=010", {done_tr[8], done_tr[9], done_tr[10]}); end
    checks++; if ({busy_tr[1], busy_tr[8], busy_tr[9]} !== 3'b110) begin errors++; $display("[TB] FAIL basic_busy_1_8_9 got=%b exp=110", {busy_tr[1], busy_tr[8], busy_tr[9]}); end
    checks++; if ({tile_idx[0], tile_lo[0], tile_hi[0], tile_pal[0]} !== {8'h24, 8'h11, 8'h22, 2'd0}) begin errors++; $display("[TB] FAIL basic_tile got=%h exp=%h", {tile_idx[0], tile_lo[0], tile_hi[0], tile_pal[0]}, {8'h24, 8'h11, 8'h22, 2'd0}); end
    checks++; if ({mem_rw[0], mem_data[0]} !== 9'h0) begin errors++; $display("[TB] FAIL basic_wr got=%h exp=0", {mem_rw[0], mem_data[0]}); end
  endtask

  task automatic test_palette();
    set_inputs(5'd6, 5'd5, 3'd0, 2'd0, 1'b1);
    pulse_start(0);
    capture(0, 12);
    checks++; if (addr_tr[1] !== 14'h20A6) begin errors++; $display("[TB] FAIL pal_nt_addr got=%h exp=20a6", addr_tr[1]); end
    checks++; if (addr_tr[3] !== 14'h23C9) begin errors++; $display("[TB] FAIL pal_at_addr got=%h exp=23c9", addr_tr[3]); end
    checks++; if (addr_tr[5] !== 14'h1300) begin errors++; $display("[TB] FAIL pal_lo_addr got=%h exp=1300", addr_tr[5]); end
    checks++; if (addr_tr[7] !== 14'h1308) begin errors++; $display("[TB] FAIL pal_hi_addr got=%h exp=1308", addr_tr[7]); end
    checks++; if (tile_pal[0] !== 2'd1) begin errors++; $display("[TB] FAIL pal_value got=%0d exp=1", tile_pal[0]); end
    checks++; if ({tile_idx[0], tile_lo[0], tile_hi[0]} !== {8'h30, 8'h5A, 8'hA5}) begin errors++; $display("[TB] FAIL pal_tile got=%h exp=305aa5", {tile_idx[0], tile_lo[0], tile_hi[0]}); end
  endtask

  task automatic test_nt_wrap();
    set_inputs(5'd31, 5'd0, 3'd0, 2'd0, 1'b0);
    pulse_start(1);
    capture(1, 20);
    checks++; if (addr_tr[1] !== 14'h201F) begin errors++; $display("[TB] FAIL wrap_nt1 got=%h exp=201f", addr_tr[1]); end
    checks++; if (addr_tr[3] !== 14'h23C7) begin errors++; $display("[TB] FAIL wrap_at1 got=%h exp=23c7", addr_tr[3]); end
    checks++; if (addr_tr[5] !== 14'h0010) begin errors++; $display("[TB] FAIL wrap_lo1 got=%h exp=0010", addr_tr[5]); end
    checks++; if (addr_tr[9] !== 14'h2400) begin errors++; $display("[TB] FAIL wrap_nt2 got=%h exp=2400", addr_tr[9]); end
    checks++; if (addr_tr[11] !== 14'h27C0) begin errors++; $display("[TB] FAIL wrap_at2 got=%h exp=27c0", addr_tr[11]); end
    checks++; if (addr_tr[13] !== 14'h0070) begin errors++; $display("[TB] FAIL wrap_lo2 got=%h exp=0070", addr_tr[13]); end
    checks++; if ({done_tr[9], done_tr[17], valid_tr[17]} !== 3'b011) begin errors++; $display("[TB] FAIL wrap_done got=%b exp=011", {done_tr[9], done_tr[17], valid_tr[17]}); end
    checks++; if (tile_idx[1] !== 8'h07) begin errors++; $display("[TB] FAIL wrap_idx2 got=%h exp=07", tile_idx[1]); end
  endtask

  task automatic test_back_to_back();
    logic [25:0] exp_tile [3];
    int n_xfer, frozen_bad, early, dones;
    logic [13:0] addr32;
    logic [8:0] held30;
    exp_tile[0] = {8'h41, 2'd2, 8'hA1, 8'hB1};
    exp_tile[1] = {8'h42, 2'd2, 8'hA2, 8'hB2};
    exp_tile[2] = {8'h43, 2'd3, 8'hA3, 8'hB3};
    n_xfer = 0; frozen_bad = 0; early = 0; dones = 0; addr32 = '0; held30 = '0;
    set_inputs(5'd2, 5'd1, 3'd1, 2'd2, 1'b0);
    tile_ready[2] = 1'b0;
    pulse_start(2);
    for (int c = 1; c <= 50; c++) begin
      tile_ready[2] = (c >= 31);
      if (c >= 17 && c <= 30 && mem_addr[2] !== 14'h0429) frozen_bad++;
      if (c < 32 && mem_addr[2] === 14'h2824) early++;
      if (c == 32) addr32 = mem_addr[2];
      if (c == 30) held30 = {tile_valid[2], tile_idx[2]};
      if (done[2] === 1'b1) dones++;
      if (tile_valid[2] === 1'b1 && tile_ready[2] === 1'b1) begin
        if (n_xfer < 3) begin
          checks++; if ({tile_idx[2], tile_pal[2], tile_lo[2], tile_hi[2]} !== exp_tile[n_xfer]) begin errors++; $display("[TB] FAIL b2b_tile%0d got=%h exp=%h", n_xfer, {tile_idx[2], tile_pal[2], tile_lo[2], tile_hi[2]}, exp_tile[n_xfer]); end
        end
        n_xfer++;
      end
      @(negedge clk);
    end
    tile_ready[2] = 1'b1;
    checks++; if (n_xfer !== 3) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=3", n_xfer); end
    checks++; if (held30 !== {1'b1, 8'h41}) begin errors++; $display("[TB] FAIL b2b_held got=%h exp=141", held30); end
    checks++; if (frozen_bad !== 0) begin errors++; $display("[TB] FAIL b2b_wait_addr got=%0d exp=0 moves", frozen_bad); end
    checks++; if (early !== 0) begin errors++; $display("[TB] FAIL b2b_early_fetch got=%0d exp=0", early); end
    checks++; if (addr32 !== 14'h2824) begin errors++; $display("[TB] FAIL b2b_resume_addr got=%h exp=2824", addr32); end
    checks++; if (dones !== 1) begin errors++; $display("[TB] FAIL b2b_done got=%0d exp=1", dones); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    set_inputs(5'd0, 5'd0, 3'd3, 2'd0, 1'b0);
    pulse_start(0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_addr[0] !== 14'h23C0) begin errors++; $display("[TB] FAIL mid_at_addr got=%h exp=23c0", mem_addr[0]); end
    tile_x0 = 5'd9;
    start_line[0] = 1'b1;
    @(negedge clk);
    start_line[0] = 1'b0;
    tile_x0 = 5'd0;
    @(negedge clk);
    checks++; if (mem_addr[0] !== 14'h0243) begin errors++; $display("[TB] FAIL busy_start_ignored got=%h exp=0243", mem_addr[0]); end
    @(negedge clk);
    checks++; if ({busy[0], mem_addr[0]} !== {1'b1, 14'h0243}) begin errors++; $display("[TB] FAIL mid_lo_d got=%h exp=%h", {busy[0], mem_addr[0]}, {1'b1, 14'h0243}); end
    rst = 1'b1;
    #1;
    checks++; if (mem_addr[0] !== 14'h0) begin errors++; $display("[TB] FAIL mid_reset_addr got=%h exp=0000", mem_addr[0]); end
    checks++; if ({tile_valid[0], busy[0], done[0]} !== 3'b000) begin errors++; $display("[TB] FAIL mid_reset_flags got=%b exp=000", {tile_valid[0], busy[0], done[0]}); end
    checks++; if ({tile_lo[0], tile_hi[0], tile_idx[0], tile_pal[0]} !== 26'h0) begin errors++; $display("[TB] FAIL mid_reset_tile got=%h exp=0", {tile_lo[0], tile_hi[0], tile_idx[0], tile_pal[0]}); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tile_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL mid_abandon got=%0d exp=0 active cycles", bad); end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_line[d] = 1'b0;
      tile_ready[d] = 1'b1;
    end
    set_inputs(5'd0, 5'd0, 3'd0, 2'd0, 1'b0);
    setup_mem();
    $display("[TB] starting ppu_bg_fetcher bench");
    test_reset();
    test_basic();
    test_palette();
    test_nt_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
